// File: rtl/paddle_ctrl.sv
// Paddle position controller: one step per debounced press, then auto-repeat
// after a hold delay, saturating at the playfield limits.
module paddle_ctrl #(
    parameter int POS_W      = 10,
    parameter int POS_MIN    = 0,
    parameter int POS_MAX    = 400,
    parameter int POS_INIT   = 200,
    parameter int STEP       = 4,
    parameter int HOLD_CYC   = 5000000,
    parameter int REPEAT_CYC = 1000000,
    parameter int CNT_W      = 23
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             up_q,
    input  logic             up_press,
    input  logic             down_q,
    input  logic             down_press,
    output logic [POS_W-1:0] pos,
    output logic             move_pulse,
    output logic             moving,
    output logic             at_top,
    output logic             at_bottom,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DELAY  = 2'd1,
        S_REPEAT = 2'd2
    } state_t;

    localparam logic [POS_W:0]   L_MIN  = (POS_W+1)'(POS_MIN);
    localparam logic [POS_W:0]   L_MAX  = (POS_W+1)'(POS_MAX);
    localparam logic [POS_W:0]   L_STEP = (POS_W+1)'(STEP);
    localparam logic [POS_W-1:0] L_INIT = POS_W'(POS_INIT);
    localparam logic [CNT_W-1:0] L_HOLD = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] L_REP  = CNT_W'(REPEAT_CYC - 1);

    state_t           r_state;
    logic             r_dir;        // 0 = up (toward POS_MIN), 1 = down
    logic [CNT_W-1:0] r_cnt;

    state_t           w_state_nxt;
    logic             w_dir_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_step;
    logic             w_dir_lvl;
    logic             w_opp_lvl;
    logic             w_abort;
    logic [POS_W:0]   w_pos_ext;
    logic [POS_W:0]   w_up_pos;
    logic [POS_W:0]   w_dn_sum;
    logic [POS_W:0]   w_dn_pos;
    logic [POS_W:0]   w_target;
    logic             w_move;

    // One extra bit so the up-step underflow and down-step overflow are visible.
    assign w_pos_ext = {1'b0, pos};
    assign w_up_pos  = (w_pos_ext < L_MIN + L_STEP) ? L_MIN : (w_pos_ext - L_STEP);
    assign w_dn_sum  = w_pos_ext + L_STEP;
    assign w_dn_pos  = (w_dn_sum > L_MAX) ? L_MAX : w_dn_sum;

    assign w_dir_lvl = r_dir ? down_q : up_q;
    assign w_opp_lvl = r_dir ? up_q : down_q;
    assign w_abort   = !w_dir_lvl || w_opp_lvl;

    always_comb begin
        w_state_nxt = r_state;
        w_dir_nxt   = r_dir;
        w_cnt_nxt   = r_cnt;
        w_step      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (up_press && !down_press) begin
                    w_step      = 1'b1;
                    w_dir_nxt   = 1'b0;
                    w_cnt_nxt   = L_HOLD;
                    w_state_nxt = S_DELAY;
                end else if (down_press && !up_press) begin
                    w_step      = 1'b1;
                    w_dir_nxt   = 1'b1;
                    w_cnt_nxt   = L_HOLD;
                    w_state_nxt = S_DELAY;
                end
            end
            S_DELAY, S_REPEAT: begin
                if (w_abort) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == '0) begin
                    w_step      = 1'b1;
                    w_cnt_nxt   = L_REP;
                    w_state_nxt = S_REPEAT;
                end else begin
                    w_cnt_nxt   = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_dir_nxt   = 1'b0;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // A step that clamps onto the current position is a silent no-op.
    assign w_target = w_dir_nxt ? w_dn_pos : w_up_pos;
    assign w_move   = w_step && (w_target != w_pos_ext);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_dir      <= 1'b0;
            r_cnt      <= '0;
            pos        <= L_INIT;
            move_pulse <= 1'b0;
            moving     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_dir      <= w_dir_nxt;
            r_cnt      <= w_cnt_nxt;
            if (w_move) begin
                pos <= w_target[POS_W-1:0];
            end
            move_pulse <= w_move;
            moving     <= (w_state_nxt == S_DELAY) || (w_state_nxt == S_REPEAT);
        end
    end

    assign at_top    = (pos == L_MIN[POS_W-1:0]);
    assign at_bottom = (pos == L_MAX[POS_W-1:0]);
    assign dbg_state = r_state;

endmodule

// File: doc/paddle_ctrl.md
Name: paddle_ctrl

Overview:
- Consumes the debounced button outputs and drives one Pong paddle's vertical position.
- Inputs per button: the stable level (q) and the one-cycle press pulse (db_clk).
- A press moves the paddle one step immediately. Holding the button auto-repeats after a hold delay, at a fixed repeat rate, with saturation at the playfield limits.
- Sits between the two per-button debouncers and the game/VGA logic; one instance per paddle.

Parameters:
- POS_W, 10, width of the position register.
- POS_MIN, 0, topmost legal position.
- POS_MAX, 400, bottommost legal position. Screen height minus paddle height.
- POS_INIT, 200, position loaded on reset.
- STEP, 4, pixels moved per step; must be >0 and <= POS_MAX-POS_MIN.
- HOLD_CYC, 5000000, clocks from the first step to the first repeat step; >=2.
- REPEAT_CYC, 1000000, clocks between repeat steps; >=2.
- CNT_W, 23, delay counter width; must hold max(HOLD_CYC, REPEAT_CYC)-1.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- reset, input, 1, asynchronous, active-low; 0 forces the reset state immediately.
- up_q, input, 1, debounced level of the up button; 1 = held.
- up_press, input, 1, one-cycle pulse on a debounced up press.
- down_q, input, 1, debounced level of the down button.
- down_press, input, 1, one-cycle pulse on a debounced down press.
- pos, output, POS_W, registered paddle position; up = toward POS_MIN.
- move_pulse, output, 1, registered; high for exactly one cycle in the cycle pos takes a new value.
- moving, output, 1, registered; high while the FSM is in DELAY or REPEAT.
- at_top, output, 1, combinational: pos == POS_MIN.
- at_bottom, output, 1, combinational: pos == POS_MAX.

Behaviour:
- Reset (reset=0, asynchronous):
  - pos=POS_INIT, move_pulse=0, moving=0.
  - state=IDLE, dir=0, counter=0.
  - Reset mid-hold abandons the hold; after release the block needs a fresh press pulse.
- Step arithmetic:
  - Computed in POS_W+1 bits.
  - Up: pos-STEP, clamped to POS_MIN.
  - Down: pos+STEP, clamped to POS_MAX.
  - If the clamped result equals the current pos, pos is unchanged and move_pulse stays 0.
- State IDLE (moving=0):
  - up_press=1 and down_press=0: take an up step, dir=up, counter=HOLD_CYC-1, go to DELAY.
  - down_press=1 and up_press=0: same with dir=down.
  - Both press pulses in the same cycle: ignored, stay in IDLE.
  - A level held without a pulse never moves the paddle.
- State DELAY:
  - Abort to IDLE, with no step, if the dir key level=0 or the opposite key level=1.
  - Otherwise, if counter==0: take a step, counter=REPEAT_CYC-1, go to REPEAT.
  - Otherwise decrement counter.
- State REPEAT:
  - Same abort rule as DELAY.
  - If counter==0: take a step and reload REPEAT_CYC-1.
  - Otherwise decrement counter.
  - Steps continue while held, even at a limit; they are no-ops with move_pulse=0.
- Press pulses arriving in DELAY or REPEAT are ignored.
- Latency:
  - A press pulse in cycle N gives the new pos and move_pulse=1 in cycle N+1.
  - First repeat step visible at N+1+HOLD_CYC.
  - Subsequent repeat steps every REPEAT_CYC cycles.
- On abort, moving falls in the cycle after the release is sampled.
- Illegal or unused state encodings recover to IDLE.

Test Plan:
Bench parameters: POS_MIN=0, POS_MAX=40, POS_INIT=20, STEP=4, HOLD_CYC=8, REPEAT_CYC=4.
1. Assert reset low for 3 cycles, then release.
   - Required: pos=20, move_pulse=0, moving=0, at_top=0, at_bottom=0.
2. Pulse up_press with up_q=1 in cycle N, drop up_q at N+2.
   - Required: pos=16 and move_pulse=1 at N+1 only; moving=0 by N+4; pos stays 16.
3. Pulse up_press at N and hold up_q=1.
   - Required: pos=16@N+1, 12@N+9, 8@N+13, 4@N+17, 0@N+21; at_top=1.
   - Required thereafter: no further move_pulse while held; moving stays 1.
4. Pulse up_press and down_press in the same cycle with both levels high.
   - Required: pos unchanged, move_pulse=0, moving=0.
5. Hold down from pos=36.
   - Required: 40 at N+1, then no move_pulse; at_bottom=1.
   - Then raise up_q mid-REPEAT: moving=0 next cycle, pos stays 40.
   - Then pulse up_press after both levels are low: pos=36.
6. Drive reset=0 asynchronously mid-DELAY, with no clock edge.
   - Required: pos=20 and moving=0 immediately.
   - After release with up_q still high: no movement until a new up_press.
